// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the nibble link: codeword type, syndrome
// constants and the reference parity/encode functions.
package hamming_pkg;

  localparam int CW_W = 7;

  typedef logic [CW_W-1:0] ham74_cw_t;

  localparam logic [2:0] SYN_OK = 3'b000;
  localparam logic [2:0] SYN_D0 = 3'b111;
  localparam logic [2:0] SYN_D1 = 3'b011;
  localparam logic [2:0] SYN_D2 = 3'b101;
  localparam logic [2:0] SYN_D3 = 3'b110;
  localparam logic [2:0] SYN_P0 = 3'b001;
  localparam logic [2:0] SYN_P1 = 3'b010;
  localparam logic [2:0] SYN_P2 = 3'b100;

  function automatic logic [2:0] ham74_parity(input logic [3:0] d);
    ham74_parity = {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  function automatic ham74_cw_t ham74_encode(input logic [3:0] d);
    ham74_encode = {ham74_parity(d), d};
  endfunction

endpackage

// File: rtl/hamming74_nibble_dec.sv
// Combinational single-error corrector for one Hamming(7,4) codeword.
// Reports whether a data bit or only a parity bit was repaired.
module hamming74_nibble_dec
  import hamming_pkg::*;
(
  input  ham74_cw_t  cw,
  output logic [3:0] data,
  output logic       dfix,
  output logic       pfix
);

  logic [2:0] syn;

  // Syndrome lookup: flip the indicated data bit, or flag a parity-only hit
  always_comb begin
    syn  = cw[6:4] ^ ham74_parity(cw[3:0]);
    data = cw[3:0];
    dfix = 1'b0;
    pfix = 1'b0;
    case (syn)
      SYN_OK: begin
        data = cw[3:0];
      end
      SYN_D0: begin
        data[0] = ~cw[0];
        dfix    = 1'b1;
      end
      SYN_D1: begin
        data[1] = ~cw[1];
        dfix    = 1'b1;
      end
      SYN_D2: begin
        data[2] = ~cw[2];
        dfix    = 1'b1;
      end
      SYN_D3: begin
        data[3] = ~cw[3];
        dfix    = 1'b1;
      end
      SYN_P0, SYN_P1, SYN_P2: begin
        pfix = 1'b1;
      end
      default: begin
        data = cw[3:0];
      end
    endcase
  end

endmodule

// File: rtl/hamming_word_decoder.sv
// Receive side of the nibble-Hamming link: corrects each codeword, reassembles
// WIDTH-bit words behind a registered valid/ready output and keeps statistics.
module hamming_word_decoder
  import hamming_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BLOCKS = WIDTH / 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  ham74_cw_t         in_cw,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [BLOCKS-1:0] out_dmask,
  output logic [BLOCKS-1:0] out_pmask,
  output logic              sync_err,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  data_corr_cnt,
  output logic [CNT_W-1:0]  par_corr_cnt
);

  localparam int IDX_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);

  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  asm_data;
  logic [BLOCKS-1:0] asm_dmask;
  logic [BLOCKS-1:0] asm_pmask;

  logic [3:0]        nib_data;
  logic              nib_dfix;
  logic              nib_pfix;

  logic              accept;
  logic              resync;
  logic              last;
  logic [IDX_W-1:0]  eff_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [WIDTH-1:0]  nxt_data;
  logic [BLOCKS-1:0] nxt_dmask;
  logic [BLOCKS-1:0] nxt_pmask;

  hamming74_nibble_dec u_nib_dec (
    .cw   (in_cw),
    .data (nib_data),
    .dfix (nib_dfix),
    .pfix (nib_pfix)
  );

  // The only stall source is a finished word the consumer has not taken yet
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Merge the corrected nibble into the assembly image; an early sof restarts the word
  always_comb begin
    resync    = accept && in_sof && (idx != '0);
    eff_idx   = resync ? '0 : idx;
    last      = (eff_idx == LAST_IDX);
    nxt_idx   = last ? '0 : (eff_idx + IDX_W'(1));
    nxt_data  = resync ? '0 : asm_data;
    nxt_dmask = resync ? '0 : asm_dmask;
    nxt_pmask = resync ? '0 : asm_pmask;
    for (int b = 0; b < BLOCKS; b++) begin
      nxt_data[b*4 +: 4] = (eff_idx == IDX_W'(b)) ? nib_data : nxt_data[b*4 +: 4];
      nxt_dmask[b]       = (eff_idx == IDX_W'(b)) ? nib_dfix : nxt_dmask[b];
      nxt_pmask[b]       = (eff_idx == IDX_W'(b)) ? nib_pfix : nxt_pmask[b];
    end
  end

  // Assembly state and nibble index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      asm_data  <= '0;
      asm_dmask <= '0;
      asm_pmask <= '0;
    end else if (accept) begin
      idx       <= nxt_idx;
      asm_data  <= nxt_data;
      asm_dmask <= nxt_dmask;
      asm_pmask <= nxt_pmask;
    end else begin
      idx       <= idx;
      asm_data  <= asm_data;
      asm_dmask <= asm_dmask;
      asm_pmask <= asm_pmask;
    end
  end

  // Output word register: loads on the last nibble, may reload while being consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dmask <= '0;
      out_pmask <= '0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_data  <= nxt_data;
      out_dmask <= nxt_dmask;
      out_pmask <= nxt_pmask;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Resync pulse and saturating correction statistics (clear has priority)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_err      <= 1'b0;
      data_corr_cnt <= '0;
      par_corr_cnt  <= '0;
    end else begin
      sync_err <= resync;
      if (cnt_clr) begin
        data_corr_cnt <= '0;
        par_corr_cnt  <= '0;
      end else begin
        if (accept && nib_dfix && !(&data_corr_cnt)) begin
          data_corr_cnt <= data_corr_cnt + CNT_W'(1);
        end else begin
          data_corr_cnt <= data_corr_cnt;
        end
        if (accept && nib_pfix && !(&par_corr_cnt)) begin
          par_corr_cnt <= par_corr_cnt + CNT_W'(1);
        end else begin
          par_corr_cnt <= par_corr_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_word_decoder.sv
// Self-checking bench for hamming_word_decoder: directed scenarios plus random
// words with injected single-bit errors checked against a behavioural model.
module tb_hamming_word_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sof, out_ready, cnt_clr;
  logic [6:0]  in_cw;
  logic        in_ready, out_valid, sync_err;
  logic [15:0] out_data, data_corr_cnt, par_corr_cnt;
  logic [3:0]  out_dmask, out_pmask;

  // Narrow-counter instance used to reach saturation quickly
  logic        s_in_valid, s_in_sof, s_cnt_clr;
  logic [6:0]  s_in_cw;
  logic        s_in_ready, s_out_valid, s_sync_err;
  logic [15:0] s_out_data;
  logic [3:0]  s_out_dmask, s_out_pmask, s_dcnt, s_pcnt;

  int n_checks = 0;
  int n_errors = 0;
  int sync_pulses = 0;
  int exp_dcnt = 0;
  int exp_pcnt = 0;

  always #5 clk = ~clk;

  hamming_word_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dmask(out_dmask), .out_pmask(out_pmask),
    .sync_err(sync_err), .cnt_clr(cnt_clr), .data_corr_cnt(data_corr_cnt),
    .par_corr_cnt(par_corr_cnt)
  );

  hamming_word_decoder #(.WIDTH(16), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_cw(s_in_cw), .in_sof(s_in_sof), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_data(s_out_data), .out_dmask(s_out_dmask), .out_pmask(s_out_pmask),
    .sync_err(s_sync_err), .cnt_clr(s_cnt_clr), .data_corr_cnt(s_dcnt),
    .par_corr_cnt(s_pcnt)
  );

  always @(negedge clk) if (sync_err === 1'b1) sync_pulses++;

  // Reference encoder straight from the parity equations
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p2, p1, p0;
    p2 = d[0] ^ d[2] ^ d[3];
    p1 = d[0] ^ d[1] ^ d[3];
    p0 = d[0] ^ d[1] ^ d[2];
    return {p2, p1, p0, d};
  endfunction

  // Offer one beat; returns at the falling edge after it was accepted
  task automatic send_beat(input logic [6:0] cw, input logic sof);
    int budget;
    in_valid = 1'b1; in_cw = cw; in_sof = sof;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL beat_timeout in_ready=%b after %0d cycles", in_ready, budget);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] c0, c1, c2, c3);
    send_beat(c0, 1'b1);
    send_beat(c1, 1'b0);
    send_beat(c2, 1'b0);
    send_beat(c3, 1'b0);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_cw = 7'h00;
    out_ready = 1'b0; cnt_clr = 1'b0;
    s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_cw = 7'h00; s_cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 16'h0000 || out_dmask !== 4'h0 || out_pmask !== 4'h0) begin
      n_errors++; $display("FAIL reset_outputs got %h/%b/%b exp 0", out_data, out_dmask, out_pmask); end
    n_checks++; if (sync_err !== 1'b0 || data_corr_cnt !== 16'h0 || par_corr_cnt !== 16'h0) begin
      n_errors++; $display("FAIL reset_stats got %b/%h/%h exp 0", sync_err, data_corr_cnt, par_corr_cnt); end
  endtask

  task automatic test_clean;
    drain();
    send_word(7'h54, 7'h43, 7'h32, 7'h71);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_errors++; $display("FAIL clean_word got v=%b %h exp v=1 1234", out_valid, out_data); end
    n_checks++; if (out_dmask !== 4'h0 || out_pmask !== 4'h0) begin
      n_errors++; $display("FAIL clean_masks got %b/%b exp 0000/0000", out_dmask, out_pmask); end
    n_checks++; if (data_corr_cnt !== 16'd0 || par_corr_cnt !== 16'd0) begin
      n_errors++; $display("FAIL clean_cnt got %0d/%0d exp 0/0", data_corr_cnt, par_corr_cnt); end
  endtask

  task automatic test_data_err;
    drain();
    send_word(7'h55, 7'h43, 7'h32, 7'h71);
    exp_dcnt++;
    n_checks++; if (out_data !== 16'h1234 || out_dmask !== 4'b0001 || out_pmask !== 4'b0000) begin
      n_errors++; $display("FAIL data_err got %h/%b/%b exp 1234/0001/0000", out_data, out_dmask, out_pmask); end
    n_checks++; if (data_corr_cnt !== 16'(exp_dcnt)) begin
      n_errors++; $display("FAIL data_err_cnt got %0d exp %0d", data_corr_cnt, exp_dcnt); end
  endtask

  task automatic test_parity_err;
    drain();
    send_word(7'h54, 7'h63, 7'h32, 7'h71);
    exp_pcnt++;
    n_checks++; if (out_data !== 16'h1234 || out_dmask !== 4'b0000 || out_pmask !== 4'b0010) begin
      n_errors++; $display("FAIL par_err got %h/%b/%b exp 1234/0000/0010", out_data, out_dmask, out_pmask); end
    n_checks++; if (par_corr_cnt !== 16'(exp_pcnt) || data_corr_cnt !== 16'(exp_dcnt)) begin
      n_errors++; $display("FAIL par_err_cnt got %0d/%0d exp %0d/%0d", data_corr_cnt, par_corr_cnt, exp_dcnt, exp_pcnt); end
  endtask

  // Random words, each nibble either clean or hit by one random bit flip
  task automatic test_random;
    logic [15:0] word;
    logic [3:0]  emask_d, emask_p;
    logic [6:0]  cw;
    int          pos;
    drain();
    for (int w = 0; w < 40; w++) begin
      word = 16'($urandom);
      emask_d = 4'h0; emask_p = 4'h0;
      for (int n = 0; n < 4; n++) begin
        pos = $urandom_range(0, 9);
        cw  = enc(word[n*4 +: 4]);
        if (pos < 7) cw[pos] = ~cw[pos];
        if (pos < 4) begin emask_d[n] = 1'b1; exp_dcnt++; end
        else if (pos < 7) begin emask_p[n] = 1'b1; exp_pcnt++; end
        send_beat(cw, (n == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      n_checks++; if (out_valid !== 1'b1 || out_data !== word || out_dmask !== emask_d || out_pmask !== emask_p) begin
        n_errors++; $display("FAIL rand_word%0d got v=%b %h/%b/%b exp %h/%b/%b",
                             w, out_valid, out_data, out_dmask, out_pmask, word, emask_d, emask_p); end
    end
    n_checks++; if (data_corr_cnt !== 16'(exp_dcnt) || par_corr_cnt !== 16'(exp_pcnt)) begin
      n_errors++; $display("FAIL rand_cnt got %0d/%0d exp %0d/%0d", data_corr_cnt, par_corr_cnt, exp_dcnt, exp_pcnt); end
  endtask

  task automatic test_back_to_back;
    drain();
    out_ready = 1'b0;
    send_word(enc(4'h4), enc(4'h3), enc(4'h2), enc(4'h1));
    in_valid = 1'b1; in_cw = enc(4'hD); in_sof = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h1234) begin
        n_errors++; $display("FAIL bp_hold%0d got rdy=%b v=%b %h exp rdy=0 v=1 1234", c, in_ready, out_valid, out_data); end
    end
    out_ready = 1'b1;
    send_beat(enc(4'hD), 1'b1);
    send_beat(enc(4'hC), 1'b0);
    send_beat(enc(4'hB), 1'b0);
    send_beat(enc(4'hA), 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin
      n_errors++; $display("FAIL bp_second got v=%b %h exp v=1 abcd", out_valid, out_data); end
  endtask

  task automatic test_resync;
    int start;
    drain();
    start = sync_pulses;
    send_beat(7'h54, 1'b1);
    send_beat(7'h43, 1'b0);
    send_beat(7'h54, 1'b1);
    n_checks++; if (sync_err !== 1'b1) begin n_errors++; $display("FAIL resync_pulse got %b exp 1", sync_err); end
    send_beat(7'h43, 1'b0);
    n_checks++; if (sync_err !== 1'b0) begin n_errors++; $display("FAIL resync_pulse_end got %b exp 0", sync_err); end
    send_beat(7'h32, 1'b0);
    send_beat(7'h71, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_dmask !== 4'h0) begin
      n_errors++; $display("FAIL resync_word got v=%b %h/%b exp v=1 1234/0000", out_valid, out_data, out_dmask); end
    n_checks++; if (sync_pulses - start != 1) begin
      n_errors++; $display("FAIL resync_count got %0d exp 1", sync_pulses - start); end
  endtask

  task automatic sat_beat(input logic [6:0] cw, input logic clr);
    s_in_valid = 1'b1; s_in_cw = cw; s_in_sof = 1'b0; s_cnt_clr = clr;
    @(negedge clk);
    s_in_valid = 1'b0; s_cnt_clr = 1'b0;
  endtask

  task automatic test_counters;
    for (int i = 0; i < 20; i++) sat_beat(7'h55, 1'b0);
    n_checks++; if (s_dcnt !== 4'hF) begin n_errors++; $display("FAIL sat_dcnt got %h exp f", s_dcnt); end
    for (int i = 0; i < 3; i++) sat_beat(7'h63, 1'b0);
    n_checks++; if (s_pcnt !== 4'd3 || s_dcnt !== 4'hF) begin
      n_errors++; $display("FAIL sat_pcnt got %h/%h exp f/3", s_dcnt, s_pcnt); end
    sat_beat(7'h55, 1'b1);
    n_checks++; if (s_dcnt !== 4'h0 || s_pcnt !== 4'h0) begin
      n_errors++; $display("FAIL sat_clr got %h/%h exp 0/0", s_dcnt, s_pcnt); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_dcnt = 0; exp_pcnt = 0;
    n_checks++; if (data_corr_cnt !== 16'd0 || par_corr_cnt !== 16'd0) begin
      n_errors++; $display("FAIL cnt_clr got %0d/%0d exp 0/0", data_corr_cnt, par_corr_cnt); end
  endtask

  task automatic test_reset_midword;
    drain();
    send_beat(7'h54, 1'b1);
    send_beat(7'h43, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    send_beat(enc(4'h8), 1'b0);
    send_beat(enc(4'h7), 1'b0);
    send_beat(enc(4'h6), 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_early got v=%b exp 0", out_valid); end
    send_beat(enc(4'h5), 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h5678) begin
      n_errors++; $display("FAIL rst_mid_word got v=%b %h exp v=1 5678", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_parity_err();
    test_random();
    test_back_to_back();
    test_resync();
    test_counters();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
